// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and response-queue payload for the UART command decoder.
package uart_cmd_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned QUEUE_DEPTH = 3;
    localparam int unsigned QCNT_W      = 2;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [BYTE_W-1:0] OPC_WRITE         = 8'h01;
    localparam logic [BYTE_W-1:0] OPC_READ          = 8'h02;
    localparam logic [BYTE_W-1:0] RESP_ACK          = 8'h06;
    localparam logic [BYTE_W-1:0] RESP_NAK          = 8'h15;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_OPC,
        ST_AH,
        ST_AL,
        ST_DH,
        ST_DL,
        ST_CSUM,
        ST_MEM,
        ST_RESP,
        ST_TXWAIT
    } state_e;

    // Bulk load of the response queue; bytes[0] is transmitted first.
    typedef struct packed {
        logic [QCNT_W-1:0]                  len;
        logic [QUEUE_DEPTH-1:0][BYTE_W-1:0] bytes;
    } resp_load_t;

    function automatic logic is_valid_opc(input logic [BYTE_W-1:0] opc);
        return (opc == OPC_WRITE) || (opc == OPC_READ);
    endfunction

endpackage

// File: rtl/uart_resp_queue.sv
// Three-entry response byte queue: loaded in one shot, drained one byte per pop.
module uart_resp_queue
    import uart_cmd_pkg::*;
(
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iLoad,
    input  resp_load_t        iLoadData,
    input  logic              iPop,
    output logic [BYTE_W-1:0] oHead,
    output logic [QCNT_W-1:0] oCount
);

    logic [QUEUE_DEPTH-1:0][BYTE_W-1:0] mem_q;
    logic [QCNT_W-1:0]                  count_q;

    // A load replaces any leftover content; pops shift toward entry 0.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            mem_q   <= '0;
            count_q <= '0;
        end else if (iLoad) begin
            mem_q   <= iLoadData.bytes;
            count_q <= iLoadData.len;
        end else if (iPop && (count_q != '0)) begin
            mem_q   <= {BYTE_W'(0), mem_q[QUEUE_DEPTH-1:1]};
            count_q <= count_q - QCNT_W'(1);
        end
    end

    assign oHead  = mem_q[0];
    assign oCount = count_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses 7-byte SYNC/OPC/ADDR/DATA/CSUM frames, issues one
// memory request per valid frame and returns ACK (+read data) or NAK bytes.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 32000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic [BYTE_W-1:0] iRxByte,
    input  logic              iRxReady,
    input  logic              iRxError,
    output logic [BYTE_W-1:0] oTxByte,
    output logic              oTxReady,
    input  logic              iTxSent,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [WORD_W-1:0] oMemAddr,
    output logic [WORD_W-1:0] oMemWrData,
    input  logic              iMemAck,
    input  logic [WORD_W-1:0] iMemRdData
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Reset asserts asynchronously, releases two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   opc_q, opc_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                tx_ready_q, tx_ready_d;

    logic                q_load;
    resp_load_t          q_payload;
    logic                q_pop;
    logic [BYTE_W-1:0]   q_head;
    logic [QCNT_W-1:0]   q_count;

    uart_resp_queue u_resp_queue (
        .iClock    (iClock),
        .iReset_n  (rst_n),
        .iLoad     (q_load),
        .iLoadData (q_payload),
        .iPop      (q_pop),
        .oHead     (q_head),
        .oCount    (q_count)
    );

    always_ff @(posedge iClock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            opc_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            xor_q      <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            tx_byte_q  <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            xor_q      <= xor_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            tx_byte_q  <= tx_byte_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Next-state and next-output logic; receive inputs only matter in HUNT..CSUM.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        xor_d      = xor_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        tx_byte_d  = tx_byte_q;
        tx_ready_d = 1'b0;
        q_load     = 1'b0;
        q_payload  = '0;
        q_pop      = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (iRxReady && !iRxError && (iRxByte == SYNC_BYTE)) begin
                    state_d = ST_OPC;
                    xor_d   = '0;
                    cnt_d   = '0;
                end
            end

            ST_OPC, ST_AH, ST_AL, ST_DH, ST_DL, ST_CSUM: begin
                if (iRxError) begin
                    state_d = ST_HUNT;
                end else if (iRxReady) begin
                    cnt_d = '0;
                    xor_d = xor_q ^ iRxByte;
                    case (state_q)
                        ST_OPC: begin
                            opc_d   = iRxByte;
                            state_d = ST_AH;
                        end
                        ST_AH: begin
                            addr_d[WORD_W-1:BYTE_W] = iRxByte;
                            state_d                 = ST_AL;
                        end
                        ST_AL: begin
                            addr_d[BYTE_W-1:0] = iRxByte;
                            state_d            = ST_DH;
                        end
                        ST_DH: begin
                            data_d[WORD_W-1:BYTE_W] = iRxByte;
                            state_d                 = ST_DL;
                        end
                        ST_DL: begin
                            data_d[BYTE_W-1:0] = iRxByte;
                            state_d            = ST_CSUM;
                        end
                        default: begin
                            if ((iRxByte == xor_q) && is_valid_opc(opc_q)) begin
                                state_d   = ST_MEM;
                                mem_req_d = 1'b1;
                                mem_we_d  = (opc_q == OPC_WRITE);
                            end else begin
                                state_d            = ST_RESP;
                                q_load             = 1'b1;
                                q_payload.len      = QCNT_W'(1);
                                q_payload.bytes[0] = RESP_NAK;
                            end
                        end
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HUNT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_MEM: begin
                if (iMemAck) begin
                    state_d            = ST_RESP;
                    mem_req_d          = 1'b0;
                    q_load             = 1'b1;
                    q_payload.bytes[0] = RESP_ACK;
                    if (mem_we_q) begin
                        q_payload.len = QCNT_W'(1);
                    end else begin
                        q_payload.len      = QCNT_W'(3);
                        q_payload.bytes[1] = iMemRdData[WORD_W-1:BYTE_W];
                        q_payload.bytes[2] = iMemRdData[BYTE_W-1:0];
                    end
                end
            end

            ST_RESP: begin
                tx_byte_d  = q_head;
                tx_ready_d = 1'b1;
                q_pop      = 1'b1;
                state_d    = ST_TXWAIT;
            end

            ST_TXWAIT: begin
                if (iTxSent) begin
                    state_d = (q_count != '0) ? ST_RESP : ST_HUNT;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    assign oTxByte    = tx_byte_q;
    assign oTxReady   = tx_ready_q;
    assign oMemReq    = mem_req_q;
    assign oMemWe     = mem_we_q;
    assign oMemAddr   = addr_q;
    assign oMemWrData = data_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: frame table plus timeout, error, drop and reset sequences.
module tb_uart_cmd_decoder;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic [7:0]  iRxByte;
    logic        iRxReady;
    logic        iRxError;
    logic [7:0]  oTxByte;
    logic        oTxReady;
    logic        iTxSent;
    logic        oMemReq;
    logic        oMemWe;
    logic [15:0] oMemAddr;
    logic [15:0] oMemWrData;
    logic        iMemAck;
    logic [15:0] iMemRdData;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (50),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iRxByte    (iRxByte),
        .iRxReady   (iRxReady),
        .iRxError   (iRxError),
        .oTxByte    (oTxByte),
        .oTxReady   (oTxReady),
        .iTxSent    (iTxSent),
        .oMemReq    (oMemReq),
        .oMemWe     (oMemWe),
        .oMemAddr   (oMemAddr),
        .oMemWrData (oMemWrData),
        .iMemAck    (iMemAck),
        .iMemRdData (iMemRdData)
    );

    always #5 iClock = ~iClock;

    typedef struct packed {
        logic [55:0] bytes;   // first byte in the top octet
        logic        mem;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        logic [1:0]  rlen;
        logic [23:0] resp;    // first response byte in the top octet
        logic        inject;
    } vec_t;

    vec_t       vecs [6];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] tx_log [$];
    bit         tx_pending = 1'b0;
    int         tx_cd = 0;
    logic [7:0] tx_hold = '0;
    int         order_err = 0;
    int         stable_err = 0;
    int         memreq_rises = 0;
    logic       memreq_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        iRxByte  = b;
        iRxReady = 1'b1;
        iRxError = err;
        @(negedge iClock);
        iRxReady = 1'b0;
        iRxError = 1'b0;
        iRxByte  = '0;
    endtask

    // Transmitter model and output monitor: acks each TX byte 4 cycles after its pulse.
    initial begin
        iTxSent = 1'b0;
        forever begin
            @(negedge iClock);
            iTxSent = 1'b0;
            if (tx_pending) begin
                if (tx_cd == 0) begin
                    iTxSent    = 1'b1;
                    tx_pending = 1'b0;
                end else begin
                    tx_cd--;
                end
            end
            if (oTxReady) begin
                if (tx_pending || iTxSent) order_err++;
                tx_log.push_back(oTxByte);
                tx_pending = 1'b1;
                tx_cd      = 3;
                tx_hold    = oTxByte;
            end else if (tx_pending && (oTxByte !== tx_hold)) begin
                stable_err++;
            end
            if (oMemReq && !memreq_prev) memreq_rises++;
            memreq_prev = oMemReq;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        tx_log.delete();
        memreq_rises = 0;
        for (int i = 0; i < 7; i++) send_byte(v.bytes[55-8*i -: 8], 1'b0);
        check($sformatf("v%0d_req_latency", idx), 32'(oMemReq), 32'(v.mem));
        if (v.mem) begin
            check($sformatf("v%0d_we", idx), 32'(oMemWe), 32'(v.we));
            check($sformatf("v%0d_addr", idx), 32'(oMemAddr), 32'(v.addr));
            if (v.we) check($sformatf("v%0d_wdata", idx), 32'(oMemWrData), 32'(v.wdata));
            repeat (3) @(negedge iClock);
            check($sformatf("v%0d_req_hold", idx), 32'({oMemReq, oMemWe, oMemAddr}),
                  32'({1'b1, v.we, v.addr}));
            iMemRdData = v.rd;
            iMemAck    = 1'b1;
            @(negedge iClock);
            iMemAck    = 1'b0;
            iMemRdData = '0;
            check($sformatf("v%0d_req_drop", idx), 32'(oMemReq), 32'(0));
            if (v.inject) begin
                // A complete valid write frame, partly flagged as errors, during the response.
                send_byte(8'hA5, 1'b0);
                send_byte(8'h01, 1'b1);
                send_byte(8'h01, 1'b0);
                send_byte(8'h00, 1'b0);
                send_byte(8'h00, 1'b0);
                send_byte(8'h00, 1'b0);
                send_byte(8'h01, 1'b0);
                send_byte(8'h01, 1'b0);
            end
        end
        repeat (40) @(negedge iClock);
        check($sformatf("v%0d_req_count", idx), 32'(memreq_rises), v.mem ? 32'd1 : 32'd0);
        check($sformatf("v%0d_tx_len", idx), 32'(tx_log.size()), 32'(v.rlen));
        for (int j = 0; j < int'(v.rlen); j++) begin
            if (j < tx_log.size())
                check($sformatf("v%0d_tx%0d", idx, j), 32'(tx_log[j]), 32'(v.resp[23-8*j -: 8]));
        end
    endtask

    initial begin
        //          bytes                     mem   we    addr      wdata     rd        len   resp          inj
        // 01^12^34^BE^EF = 76
        vecs[0] = '{56'hA5_01_12_34_BE_EF_76, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 2'd1, 24'h06_00_00, 1'b0};
        vecs[1] = '{56'hA5_02_00_10_00_00_12, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hCAFE, 2'd3, 24'h06_CA_FE, 1'b0};
        vecs[2] = '{56'hA5_01_12_34_BE_EF_00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd1, 24'h15_00_00, 1'b0};
        // unknown opcode with correct checksum 03^00^01^00^00 = 02
        vecs[3] = '{56'hA5_03_00_01_00_00_02, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd1, 24'h15_00_00, 1'b0};
        // SYNC value as address data: 01^A5^A5^00^01 = 00
        vecs[4] = '{56'hA5_01_A5_A5_00_01_00, 1'b1, 1'b1, 16'hA5A5, 16'h0001, 16'h0000, 2'd1, 24'h06_00_00, 1'b0};
        // read with ignored data bytes, 02^FF^00^12^34 = DB, bytes injected while responding
        vecs[5] = '{56'hA5_02_FF_00_12_34_DB, 1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h1357, 2'd3, 24'h06_13_57, 1'b1};

        iReset_n   = 1'b0;
        iRxByte    = '0;
        iRxReady   = 1'b0;
        iRxError   = 1'b0;
        iMemAck    = 1'b0;
        iMemRdData = '0;
        repeat (2) @(negedge iClock);
        check("reset_outputs", 32'({oMemReq, oMemWe, oTxReady, oTxByte}), 32'(0));
        check("reset_addr_data", {oMemAddr, oMemWrData}, 32'(0));
        iReset_n = 1'b1;
        repeat (4) @(negedge iClock);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Inter-byte timeout: a 45-cycle gap is tolerated, 50 silent cycles abort.
        tx_log.delete();
        memreq_rises = 0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (45) @(negedge iClock);
        send_byte(8'h12, 1'b0);
        repeat (50) @(negedge iClock);
        check("timeout_no_tx", 32'(tx_log.size()), 32'(0));
        check("timeout_no_req", 32'(memreq_rises), 32'(0));
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        run_vec(vecs[0], 10);

        // Receiver error coinciding with the AL byte aborts the frame.
        tx_log.delete();
        memreq_rises = 0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'h76, 1'b0);
        repeat (30) @(negedge iClock);
        check("rxerr_no_tx", 32'(tx_log.size()), 32'(0));
        check("rxerr_no_req", 32'(memreq_rises), 32'(0));
        run_vec(vecs[1], 11);

        // Asynchronous reset while a request is outstanding; the late ack must be ignored.
        tx_log.delete();
        memreq_rises = 0;
        for (int i = 0; i < 7; i++) send_byte(vecs[0].bytes[55-8*i -: 8], 1'b0);
        check("rst_req_before", 32'(oMemReq), 32'(1));
        #2 iReset_n = 1'b0;
        #1;
        check("rst_req_immediate", 32'(oMemReq), 32'(0));
        check("rst_outputs_clear", 32'({oMemWe, oTxReady, oTxByte}), 32'(0));
        check("rst_addr_data_clear", {oMemAddr, oMemWrData}, 32'(0));
        repeat (3) @(negedge iClock);
        iReset_n = 1'b1;
        repeat (3) @(negedge iClock);
        iMemAck = 1'b1;
        @(negedge iClock);
        iMemAck = 1'b0;
        repeat (30) @(negedge iClock);
        check("rst_late_ack_req", 32'(oMemReq), 32'(0));
        check("rst_late_ack_no_tx", 32'(tx_log.size()), 32'(0));
        check("rst_req_count", 32'(memreq_rises), 32'(1));
        run_vec(vecs[0], 12);

        check("tx_order", 32'(order_err), 32'(0));
        check("tx_byte_stable", 32'(stable_err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
